cu_pipe_ctrl: RTL and testbench
===============================

CU_PIPE_CTRL -- requirements
Module: cu_pipe_ctrl

Interface
REQ-001 Parameter OP_W, default 8: opcode width, and the width of inst.
REQ-002 Parameter REG_AW, default 6: register-file address width (aa, ab, ad).
REQ-003 Parameter PC_W, default 8: program-counter width; INSTR_W = OP_W + 3*REG_AW, laid out as {op, rd, ra, rb}.
REQ-004 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  the single clock; all state changes on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 imem_req  out  1  instruction-fetch request.
REQ-008 imem_addr  out  PC_W  fetch address, equal to the current PC.
REQ-009 imem_ack  in  1  fetch data valid this cycle.
REQ-010 imem_data  in  INSTR_W  fetched instruction word.
REQ-011 zero_flag  in  1  ALU zero result, sampled by BZ.
REQ-012 aa, ab  out  REG_AW each  register-file read addresses, carrying ra and rb.
REQ-013 ad  out  REG_AW  register-file write address, carrying rd.
REQ-014 wr  out  1  register-file write strobe.
REQ-015 inst  out  OP_W  ALU opcode for the execute cycle; 0 at all other times.
REQ-016 halted  out  1  processor stopped.

Function
REQ-017 States: FETCH, DECODE, EXEC, WB, HALT; all outputs registered.
- FETCH: imem_req=1; hold FETCH until imem_ack=1; on ack, latch imem_data into IR and go to DECODE.
- DECODE: aa=ra, ab=rb; lasts 1 cycle.
- EXEC: inst=op; aa and ab held; lasts 1 cycle.
- WB: ad=rd, wr=1; lasts 1 cycle, then PC+1 and go to FETCH.
REQ-018 Opcode 0x00 (NOP): from EXEC go straight to FETCH with PC+1; no WB cycle, wr stays 0.
REQ-019 Opcode 0xFF (HALT): from EXEC go to HALT; halted=1 and imem_req=0 until rst.
REQ-020 Opcode 0xF0 (JMP): PC <= low PC_W bits of {ra,rb}; EXEC then FETCH; no WB.
REQ-021 Opcode 0xF1 (BZ): zero_flag is sampled in EXEC.
- zero_flag=1: jump as JMP.
- zero_flag=0: PC+1.
- No WB in either case.
REQ-022 Every other opcode is an ALU op with write-back. Latency: ack in cycle t, inst valid in cycle t+2, wr=1 in cycle t+3, next imem_req in cycle t+4.
REQ-023 PC increment wraps modulo 2^PC_W (all-ones + 1 = 0).
REQ-024 imem_ack is ignored outside FETCH; imem_data is sampled only on the ack cycle.
REQ-025 wr is asserted for exactly one cycle per ALU instruction and never in any other state.

Reset
REQ-026 rst=1 at a rising edge, in any state including mid-fetch or WB, forces the next cycle to:
- state FETCH, PC=0, IR=0;
- aa=ab=ad=0, wr=0, inst=0, halted=0;
- imem_req=1.
REQ-027 While rst is held, the block stays in the reset state and ignores imem_ack.

Configuration
REQ-028 Macro CU_BRANCH_EN.
- Defined: BZ behaves per REQ-021.
- Undefined: opcode 0xF1 decodes as NOP (PC+1, no WB), zero_flag is unused, and JMP is unaffected.

Verification
REQ-029 Reset, then ack {op=0x12, rd=5, ra=3, rb=4} at cycle t -> aa=3/ab=4 at t+1; inst=0x12 at t+2; ad=5, wr=1 at t+3; imem_addr=1 at t+4.
REQ-030 imem_ack held low for 5 cycles in FETCH -> imem_req stays 1, PC unchanged, wr=0 throughout.
REQ-031 JMP with {ra,rb} low bits = 0x40 -> next imem_addr=0x40, no wr pulse; PC=0xFF followed by an ALU op -> next imem_addr=0x00.
REQ-032 BZ to 0x20 with zero_flag=1 -> imem_addr=0x20; with zero_flag=0 -> PC+1. Without CU_BRANCH_EN -> PC+1 regardless of zero_flag.
REQ-033 HALT -> halted=1 and imem_req=0 for 20 cycles; then rst=1 for 1 cycle -> halted=0, imem_addr=0.
REQ-034 rst asserted during the WB cycle -> wr=0 on the next cycle, PC=0, all outputs 0.

Source files
------------

// File: rtl/cu_pipe_ctrl_if.sv
// rtl/cu_pipe_ctrl_if.sv - fetch, register-file and status signals of cu_pipe_ctrl
interface cu_pipe_ctrl_if #(
  parameter int OP_W   = 8,
  parameter int REG_AW = 6,
  parameter int PC_W   = 8
);
  localparam int INSTR_W = OP_W + 3 * REG_AW;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_data;
  logic               zero_flag;
  logic [REG_AW-1:0]  aa;
  logic [REG_AW-1:0]  ab;
  logic [REG_AW-1:0]  ad;
  logic               wr;
  logic [OP_W-1:0]    inst;
  logic               halted;

  modport master (
    output imem_req, imem_addr, aa, ab, ad, wr, inst, halted,
    input  imem_ack, imem_data, zero_flag
  );

  modport slave (
    input  imem_req, imem_addr, aa, ab, ad, wr, inst, halted,
    output imem_ack, imem_data, zero_flag
  );
endinterface

// File: rtl/cu_pipe_ctrl.sv
// rtl/cu_pipe_ctrl.sv - multi-cycle fetch/decode/exec/wb control unit
// Optional macro CU_BRANCH_EN enables the BZ conditional branch (otherwise 0xF1 acts as NOP).
module cu_pipe_ctrl #(
  parameter int OP_W   = 8,
  parameter int REG_AW = 6,
  parameter int PC_W   = 8
) (
  input logic            clk,
  input logic            rst,
  cu_pipe_ctrl_if.master bus
);
  localparam int INSTR_W = OP_W + 3 * REG_AW;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [OP_W-1:0] OP_NOP  = '0;
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(8'hF0);
  localparam logic [OP_W-1:0] OP_BZ   = OP_W'(8'hF1);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(8'hFF);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [REG_AW-1:0]  aa_q, aa_d, ab_q, ab_d, ad_q, ad_d;
  logic [OP_W-1:0]    inst_q, inst_d;
  logic               req_q, req_d, wr_q, wr_d, halted_q, halted_d;

  logic [OP_W-1:0]    ir_op;
  logic [REG_AW-1:0]  ir_rd, ir_ra, ir_rb;
  logic [PC_W-1:0]    pc_inc, jmp_tgt;

  assign ir_op   = ir_q[INSTR_W-1 -: OP_W];
  assign ir_rd   = ir_q[3*REG_AW-1 -: REG_AW];
  assign ir_ra   = ir_q[2*REG_AW-1 -: REG_AW];
  assign ir_rb   = ir_q[REG_AW-1:0];
  assign pc_inc  = pc_q + PC_W'(1);
  assign jmp_tgt = PC_W'({ir_ra, ir_rb});

`ifndef CU_BRANCH_EN
  logic unused_zero_flag;
  assign unused_zero_flag = bus.zero_flag;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    aa_d    = aa_q;
    ab_d    = ab_q;
    ad_d    = ad_q;
    case (state_q)
      S_FETCH: begin
        if (bus.imem_ack) begin
          ir_d    = bus.imem_data;
          aa_d    = bus.imem_data[2*REG_AW-1 -: REG_AW];
          ab_d    = bus.imem_data[REG_AW-1:0];
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (ir_op)
          OP_NOP: begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          OP_JMP: begin
            pc_d    = jmp_tgt;
            state_d = S_FETCH;
          end
          OP_BZ: begin
`ifdef CU_BRANCH_EN
            pc_d    = bus.zero_flag ? jmp_tgt : pc_inc;
`else
            pc_d    = pc_inc;
`endif
            state_d = S_FETCH;
          end
          default: begin
            ad_d    = ir_rd;
            state_d = S_WB;
          end
        endcase
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    // Status outputs are a pure function of the state being entered, so they register cleanly.
    req_d    = (state_d == S_FETCH);
    wr_d     = (state_d == S_WB);
    halted_d = (state_d == S_HALT);
    inst_d   = (state_d == S_EXEC) ? ir_op : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      aa_q     <= '0;
      ab_q     <= '0;
      ad_q     <= '0;
      inst_q   <= '0;
      req_q    <= 1'b1;
      wr_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      aa_q     <= aa_d;
      ab_q     <= ab_d;
      ad_q     <= ad_d;
      inst_q   <= inst_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.aa        = aa_q;
  assign bus.ab        = ab_q;
  assign bus.ad        = ad_q;
  assign bus.wr        = wr_q;
  assign bus.inst      = inst_q;
  assign bus.halted    = halted_q;
endmodule

// File: tb/tb_cu_pipe_ctrl.sv
// tb/tb_cu_pipe_ctrl.sv - randomized self-checking bench for cu_pipe_ctrl
module tb_cu_pipe_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;
  int pc    = 0;

`ifdef CU_BRANCH_EN
  localparam bit BR_EN = 1'b1;
`else
  localparam bit BR_EN = 1'b0;
`endif

  cu_pipe_ctrl_if #(.OP_W(8), .REG_AW(6), .PC_W(8)) bus ();

  cu_pipe_ctrl #(.OP_W(8), .REG_AW(6), .PC_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".req"}, int'(bus.imem_req), 1);
    check_eq({tag, ".addr"}, int'(bus.imem_addr), 0);
    check_eq({tag, ".aa"}, int'(bus.aa), 0);
    check_eq({tag, ".ab"}, int'(bus.ab), 0);
    check_eq({tag, ".ad"}, int'(bus.ad), 0);
    check_eq({tag, ".wr"}, int'(bus.wr), 0);
    check_eq({tag, ".inst"}, int'(bus.inst), 0);
    check_eq({tag, ".halted"}, int'(bus.halted), 0);
  endtask

  // Instruction-level model: one call fetches, executes and retires a single instruction.
  task automatic run_instr(input int op, input int rd, input int ra, input int rb,
                           input bit zf, input int delay, input bit rst_in_wb);
    int tgt;
    bit has_wb;
    tgt    = ((ra << 6) | rb) & 255;
    has_wb = !(op == 'h00 || op == 'hF0 || op == 'hF1 || op == 'hFF);
    for (int d = 0; d < delay; d++) begin
      check_eq("wait.req", int'(bus.imem_req), 1);
      check_eq("wait.addr", int'(bus.imem_addr), pc);
      check_eq("wait.wr", int'(bus.wr), 0);
      bus.imem_ack  = 1'b0;
      bus.imem_data = 26'($urandom);
      step();
    end
    check_eq("fetch.req", int'(bus.imem_req), 1);
    check_eq("fetch.addr", int'(bus.imem_addr), pc);
    check_eq("fetch.inst", int'(bus.inst), 0);
    bus.imem_ack  = 1'b1;
    bus.imem_data = {8'(op), 6'(rd), 6'(ra), 6'(rb)};
    step();
    check_eq("dec.aa", int'(bus.aa), ra);
    check_eq("dec.ab", int'(bus.ab), rb);
    check_eq("dec.req", int'(bus.imem_req), 0);
    check_eq("dec.inst", int'(bus.inst), 0);
    bus.imem_ack  = 1'($urandom);
    bus.imem_data = 26'($urandom);
    step();
    check_eq("exec.inst", int'(bus.inst), op);
    check_eq("exec.aa", int'(bus.aa), ra);
    check_eq("exec.ab", int'(bus.ab), rb);
    check_eq("exec.wr", int'(bus.wr), 0);
    bus.zero_flag = zf;
    step();
    bus.zero_flag = 1'($urandom);
    bus.imem_ack  = 1'b0;
    if (op == 'hFF) begin
      for (int c = 0; c < 20; c++) begin
        check_eq("halt.halted", int'(bus.halted), 1);
        check_eq("halt.req", int'(bus.imem_req), 0);
        check_eq("halt.wr", int'(bus.wr), 0);
        bus.imem_ack = 1'($urandom);
        step();
      end
      return;
    end
    if (has_wb) begin
      check_eq("wb.wr", int'(bus.wr), 1);
      check_eq("wb.ad", int'(bus.ad), rd);
      check_eq("wb.inst", int'(bus.inst), 0);
      check_eq("wb.req", int'(bus.imem_req), 0);
      if (rst_in_wb) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("rstwb");
        pc = 0;
        return;
      end
      bus.imem_ack = 1'($urandom);
      step();
      bus.imem_ack = 1'b0;
      check_eq("post.wr", int'(bus.wr), 0);
      pc = (pc + 1) % 256;
    end else begin
      check_eq("nowb.wr", int'(bus.wr), 0);
      if (op == 'hF0 || (op == 'hF1 && BR_EN && zf)) pc = tgt;
      else pc = (pc + 1) % 256;
    end
  endtask

  initial begin
    bus.imem_ack  = 1'b1;
    bus.imem_data = {8'h12, 6'd5, 6'd3, 6'd4};
    bus.zero_flag = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_reset_state("rsthold");
    end
    bus.imem_ack = 1'b0;
    rst = 1'b0;
    pc  = 0;

    run_instr('h12, 5, 3, 4, 1'b0, 0, 1'b0);
    check_eq("lat.addr", int'(bus.imem_addr), 1);
    run_instr('h33, 7, 1, 2, 1'b0, 5, 1'b0);
    run_instr('hF0, 0, 1, 0, 1'b0, 1, 1'b0);
    check_eq("jmp.addr", int'(bus.imem_addr), 'h40);
    run_instr('hF1, 0, 0, 'h20, 1'b1, 0, 1'b0);
    check_eq("bz1.addr", int'(bus.imem_addr), BR_EN ? 'h20 : 'h41);
    run_instr('hF1, 0, 0, 'h30, 1'b0, 2, 1'b0);
    run_instr('hF0, 0, 3, 'h3F, 1'b0, 0, 1'b0);
    check_eq("jmpff.addr", int'(bus.imem_addr), 'hFF);
    run_instr('h01, 9, 8, 7, 1'b1, 0, 1'b0);
    check_eq("wrap.addr", int'(bus.imem_addr), 0);
    run_instr('h00, 1, 2, 3, 1'b1, 1, 1'b0);

    for (int n = 0; n < 60; n++) begin
      int k;
      int op;
      k = int'($urandom % 6);
      case (k)
        0: op = 'h00;
        1: op = 'hF0;
        2: op = 'hF1;
        default: op = 1 + int'($urandom % 'hEF);
      endcase
      run_instr(op, int'($urandom % 64), int'($urandom % 64), int'($urandom % 64),
                1'($urandom), int'($urandom % 4), 1'b0);
    end

    run_instr('h55, 6, 2, 1, 1'b0, 0, 1'b1);
    run_instr('h21, 3, 4, 5, 1'b0, 0, 1'b0);
    run_instr('hFF, 0, 0, 0, 1'b0, 1, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("unhalt");
    pc = 0;
    run_instr('h44, 2, 2, 2, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
